float_alu_seq: RTL and testbench

Multi-cycle floating-point arithmetic unit for the coprocessor. It performs add, sub and mul on the team's parametrised float format: sign, then exponent, then mantissa, packed with the sign in the MSB. Operands enter and results leave through valid/ready handshakes. Results saturate on overflow and flush to zero on underflow, and each case raises a status flag.

---
 rtl/float_alu_seq_if.sv | 28 ++
 rtl/float_alu_seq.sv | 249 ++++++++++++++++++++++++
 tb/tb_float_alu_seq.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/float_alu_seq_if.sv
// Handshake bundle for float_alu_seq: operand channel in, result channel out.
interface float_alu_seq_if #(
  parameter int N_mantisse = 23,
  parameter int N_exposant = 8
);
  localparam int W = 1 + N_exposant + N_mantisse;

  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         ovf;
  logic         unf;

  modport master (
    output in_valid, op, op1, op2, out_ready,
    input  in_ready, out_valid, result, ovf, unf
  );

  modport slave (
    input  in_valid, op, op1, op2, out_ready,
    output in_ready, out_valid, result, ovf, unf
  );
endinterface

// File: rtl/float_alu_seq.sv
// Multi-cycle add/sub/mul on a {sign, exp, mant} float format with saturation
// on overflow and flush-to-zero on underflow; one operation in flight.
module float_alu_seq #(
  parameter int N_mantisse = 23,
  parameter int N_exposant = 8
) (
  input  logic           clk,
  input  logic           reset,
  float_alu_seq_if.slave bus
);
  localparam int M  = N_mantisse;
  localparam int E  = N_exposant;
  localparam int W  = 1 + E + M;
  localparam int XW = E + 7;
  localparam int SW = M + 3;
  localparam int PW = 2 * M + 2;

  localparam logic        [XW-1:0] BIAS    = XW'(2 ** (E - 1) - 1);
  localparam logic signed [XW-1:0] EXP_MAX = XW'(2 ** E - 2);
  localparam logic signed [XW-1:0] EXP_MIN = XW'(1);
  localparam logic        [E-1:0]  EXP_SAT = E'(2 ** E - 2);
  localparam logic        [XW-1:0] SHIFT_LIMIT = XW'(M + 2);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    EXEC,
    NORM,
    PACK,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic [1:0]   op_q;
  logic [W-1:0] op1_q;
  logic [W-1:0] op2_q;

  logic         big_sign;
  logic         small_sign;
  logic         any_zero;
  logic [E-1:0] big_exp;
  logic [E-1:0] small_exp;
  logic [E-1:0] exp_diff;
  logic [M:0]   big_sig;
  logic [M:0]   small_sig;

  logic                 res_sign;
  logic                 res_zero;
  logic signed [XW-1:0] res_exp;
  logic [SW-1:0]        res_sig;

  logic [W-1:0] result_q;
  logic         ovf_q;
  logic         unf_q;

  logic in_ready_c;
  logic out_valid_c;

  // Unpack: zero detection, hidden bit insertion, sub sign flip, and ordering
  // by magnitude so the add path always subtracts the smaller from the larger.
  logic         u_s1, u_s2, u_z1, u_z2, u_swap;
  logic [E-1:0] u_e1, u_e2;
  logic [W-2:0] u_key1, u_key2;
  logic [M:0]   u_sig1, u_sig2;

  always_comb begin
    u_s1   = op1_q[W-1];
    u_s2   = op2_q[W-1] ^ (op_q == OP_SUB);
    u_e1   = op1_q[W-2 -: E];
    u_e2   = op2_q[W-2 -: E];
    u_z1   = (u_e1 == '0);
    u_z2   = (u_e2 == '0);
    u_key1 = u_z1 ? '0 : op1_q[W-2:0];
    u_key2 = u_z2 ? '0 : op2_q[W-2:0];
    u_sig1 = u_z1 ? '0 : {1'b1, op1_q[M-1:0]};
    u_sig2 = u_z2 ? '0 : {1'b1, op2_q[M-1:0]};
    u_swap = (u_key2 > u_key1);
  end

  // Execute: significand product for mul, aligned magnitude add/sub otherwise.
  logic [PW-1:0]        ex_prod;
  logic [M+1:0]         ex_prod_top;
  logic                 ex_prod_hi;
  logic [M:0]           ex_mul_sig;
  logic signed [XW-1:0] ex_mul_exp;
  logic [SW-1:0]        ex_big_ext;
  logic [SW-1:0]        ex_small_ext;
  logic [SW:0]          ex_sum;
  logic [SW-1:0]        ex_add_sig;
  logic signed [XW-1:0] ex_add_exp;

  always_comb begin
    ex_prod      = {{(M + 1){1'b0}}, big_sig} * {{(M + 1){1'b0}}, small_sig};
    ex_prod_top  = (M + 2)'(ex_prod >> M);
    ex_prod_hi   = ex_prod_top[M+1];
    ex_mul_sig   = ex_prod_hi ? ex_prod_top[M+1:1] : ex_prod_top[M:0];
    ex_mul_exp   = XW'(big_exp) + XW'(small_exp) - BIAS + XW'(ex_prod_hi);
    ex_big_ext   = {big_sig, 2'b00};
    ex_small_ext = (XW'(exp_diff) > SHIFT_LIMIT) ? '0 : ({small_sig, 2'b00} >> exp_diff);
    if (big_sign ^ small_sign) begin
      ex_sum = {1'b0, ex_big_ext} - {1'b0, ex_small_ext};
    end else begin
      ex_sum = {1'b0, ex_big_ext} + {1'b0, ex_small_ext};
    end
    ex_add_sig = ex_sum[SW] ? ex_sum[SW:1] : ex_sum[SW-1:0];
    ex_add_exp = XW'(big_exp) + XW'(ex_sum[SW]);
  end

  // Pack: saturate, flush, or truncate the guard bits away.
  logic [W-1:0] pk_result;
  logic         pk_ovf;
  logic         pk_unf;

  always_comb begin
    pk_result = '0;
    pk_ovf    = 1'b0;
    pk_unf    = 1'b0;
    if (res_zero) begin
      pk_result = '0;
    end else if (res_exp > EXP_MAX) begin
      pk_result = {res_sign, EXP_SAT, {M{1'b1}}};
      pk_ovf    = 1'b1;
    end else if (res_exp < EXP_MIN) begin
      pk_result = '0;
      pk_unf    = 1'b1;
    end else begin
      pk_result = {res_sign, res_exp[E-1:0], res_sig[SW-2 -: M]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) next_state = UNPACK;
      end
      UNPACK: next_state = EXEC;
      EXEC: begin
        if (op_q == OP_ADD || op_q == OP_SUB) next_state = NORM;
        else                                   next_state = PACK;
      end
      NORM: begin
        if (res_zero || res_sig[SW-1]) next_state = PACK;
      end
      PACK: next_state = DONE;
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      big_sign   <= 1'b0;
      small_sign <= 1'b0;
      any_zero   <= 1'b0;
      big_exp    <= '0;
      small_exp  <= '0;
      exp_diff   <= '0;
      big_sig    <= '0;
      small_sig  <= '0;
      res_sign   <= 1'b0;
      res_zero   <= 1'b0;
      res_exp    <= '0;
      res_sig    <= '0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_q  <= bus.op;
            op1_q <= bus.op1;
            op2_q <= bus.op2;
          end
        end
        UNPACK: begin
          any_zero   <= u_z1 | u_z2;
          big_sign   <= u_swap ? u_s2   : u_s1;
          small_sign <= u_swap ? u_s1   : u_s2;
          big_exp    <= u_swap ? u_e2   : u_e1;
          small_exp  <= u_swap ? u_e1   : u_e2;
          big_sig    <= u_swap ? u_sig2 : u_sig1;
          small_sig  <= u_swap ? u_sig1 : u_sig2;
          exp_diff   <= u_swap ? (u_e2 - u_e1) : (u_e1 - u_e2);
        end
        EXEC: begin
          if (op_q == OP_MUL) begin
            res_sign <= big_sign ^ small_sign;
            res_zero <= any_zero;
            res_exp  <= ex_mul_exp;
            res_sig  <= {ex_mul_sig, 2'b00};
          end else if (op_q == OP_ADD || op_q == OP_SUB) begin
            res_sign <= big_sign;
            res_zero <= (ex_sum == '0);
            res_exp  <= ex_add_exp;
            res_sig  <= ex_add_sig;
          end else begin
            res_sign <= 1'b0;
            res_zero <= 1'b1;
            res_exp  <= '0;
            res_sig  <= '0;
          end
        end
        NORM: begin
          if (!res_zero && !res_sig[SW-1]) begin
            res_sig <= res_sig << 1;
            res_exp <= res_exp - XW'(1);
          end
        end
        PACK: begin
          result_q <= pk_result;
          ovf_q    <= pk_ovf;
          unf_q    <= pk_unf;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.result    = result_q;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;
endmodule

// File: tb/tb_float_alu_seq.sv
// Directed bench for float_alu_seq: default 8/23 format plus a 5/10 instance.
module tb_float_alu_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic        sel;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;

  int n_asserts = 0;
  int n_fail    = 0;

  float_alu_seq_if #(.N_mantisse(23), .N_exposant(8)) b8 ();
  float_alu_seq_if #(.N_mantisse(10), .N_exposant(5)) b5 ();

  assign b8.in_valid  = in_valid & ~sel;
  assign b5.in_valid  = in_valid & sel;
  assign b8.op        = op;
  assign b5.op        = op;
  assign b8.op1       = a;
  assign b8.op2       = b;
  assign b5.op1       = a[15:0];
  assign b5.op2       = b[15:0];
  assign b8.out_ready = out_ready;
  assign b5.out_ready = out_ready;

  logic        ov;
  logic        ir;
  logic [31:0] res;
  logic        ovf_o;
  logic        unf_o;

  assign ov    = sel ? b5.out_valid : b8.out_valid;
  assign ir    = sel ? b5.in_ready  : b8.in_ready;
  assign res   = sel ? {16'h0000, b5.result} : b8.result;
  assign ovf_o = sel ? b5.ovf : b8.ovf;
  assign unf_o = sel ? b5.unf : b8.unf;

  float_alu_seq #(.N_mantisse(23), .N_exposant(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (b8)
  );

  float_alu_seq #(.N_mantisse(10), .N_exposant(5)) dut5 (
    .clk   (clk),
    .reset (reset),
    .bus   (b5)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_asserts++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic apply_stimulus(input logic s, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    sel      = s;
    op       = o;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    #1;
    check_output("in_ready_idle", {31'b0, ir}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts rising edges after the accept edge until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!ov && lat < 60);
  endtask

  task automatic run_op(input string tag, input logic s, input logic [1:0] o,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_res, input logic exp_ovf,
                        input logic exp_unf, input int exp_lat);
    int lat;
    apply_stimulus(s, o, x, y);
    wait_result(lat);
    check_output({tag, ".valid"},  {31'b0, ov}, 32'd1);
    check_output({tag, ".lat"},    32'(lat), 32'(exp_lat));
    check_output({tag, ".result"}, res, exp_res);
    check_output({tag, ".ovf"},    {31'b0, ovf_o}, {31'b0, exp_ovf});
    check_output({tag, ".unf"},    {31'b0, unf_o}, {31'b0, exp_unf});
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check_output({tag, ".release_valid"}, {31'b0, ov}, 32'd0);
    check_output({tag, ".release_ready"}, {31'b0, ir}, 32'd1);
  endtask

  initial begin
    int  lat;
    bit  seen;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sel       = 1'b0;
    op        = 2'b00;
    a         = '0;
    b         = '0;
    $display("[TB] start");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("rst.in_ready",  {31'b0, ir},    32'd1);
    check_output("rst.out_valid", {31'b0, ov},    32'd0);
    check_output("rst.result",    res,            32'h0);
    check_output("rst.ovf",       {31'b0, ovf_o}, 32'd0);
    check_output("rst.unf",       {31'b0, unf_o}, 32'd0);

    run_op("mul_1p5x2",  1'b0, 2'b10, 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 3);
    run_op("add_carry",  1'b0, 2'b00, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 4);
    run_op("sub_norm2",  1'b0, 2'b01, 32'h3F800000, 32'h3F400000, 32'h3E800000, 1'b0, 1'b0, 6);
    run_op("sub_cancel", 1'b0, 2'b01, 32'h40490FDB, 32'h40490FDB, 32'h00000000, 1'b0, 1'b0, 4);
    run_op("mul_ovf",    1'b0, 2'b10, 32'h7F000000, 32'h7F000000, 32'h7F7FFFFF, 1'b1, 1'b0, 3);
    run_op("mul_unf",    1'b0, 2'b10, 32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1, 3);
    run_op("mul_zero",   1'b0, 2'b10, 32'hBF800000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 3);
    run_op("sub_from0",  1'b0, 2'b01, 32'h00000000, 32'hC0400000, 32'h40400000, 1'b0, 1'b0, 4);
    run_op("reserved",   1'b0, 2'b11, 32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 3);

    // Back-pressure: result must hold while in_valid pulses are ignored.
    apply_stimulus(1'b0, 2'b10, 32'h3FC00000, 32'h40000000);
    wait_result(lat);
    check_output("bp.lat", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      op       = 2'b00;
      a        = 32'h40000000 + 32'(i);
      b        = 32'h3F800000;
      #1;
      check_output("bp.valid",    {31'b0, ov},    32'd1);
      check_output("bp.result",   res,            32'h40400000);
      check_output("bp.in_ready", {31'b0, ir},    32'd0);
      check_output("bp.flags",    {30'b0, ovf_o, unf_o}, 32'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check_output("bp.release_valid", {31'b0, ov}, 32'd0);
    check_output("bp.release_ready", {31'b0, ir}, 32'd1);
    run_op("bp_next_add", 1'b0, 2'b00, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 4);

    // Reset while a long subtraction is still normalising.
    apply_stimulus(1'b0, 2'b01, 32'h3F800000, 32'h3F7FFFFF);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_output("abort.in_ready",  {31'b0, ir}, 32'd1);
    check_output("abort.out_valid", {31'b0, ov}, 32'd0);
    check_output("abort.result",    res,         32'h0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ov) seen = 1'b1;
    end
    check_output("abort.no_output", {31'b0, seen}, 32'd0);
    run_op("abort_next_mul", 1'b0, 2'b10, 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 3);

    // Reduced 5-bit exponent / 10-bit mantissa instance.
    run_op("h_mul",   1'b1, 2'b10, 32'h3E00, 32'h4000, 32'h4200, 1'b0, 1'b0, 3);
    run_op("h_add",   1'b1, 2'b00, 32'h3C00, 32'h3C00, 32'h4000, 1'b0, 1'b0, 4);
    run_op("h_sub",   1'b1, 2'b01, 32'h3C00, 32'h4000, 32'hBC00, 1'b0, 1'b0, 5);
    run_op("h_trunc", 1'b1, 2'b00, 32'h3C00, 32'h1001, 32'h3C00, 1'b0, 1'b0, 4);
    run_op("h_ovf",   1'b1, 2'b10, 32'h7800, 32'h7800, 32'h7BFF, 1'b1, 1'b0, 3);
    run_op("h_unf",   1'b1, 2'b01, 32'h0600, 32'h0400, 32'h0000, 1'b0, 1'b1, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
